abuf_reader: RTL and testbench
==============================

ABUF_READER -- requirements
Module: abuf_reader

Interface
REQ-001 Parameters: PE_NUM, default 32, total PEs (GRP_NUM = PE_NUM/4 groups); BUF_DEPTH, default 256, accum buffer depth; ADDR_W, default bw(BUF_DEPTH), buffer address width; RD_LAT, default 2, cycles from abuf_rd_en high to abuf_rd_data valid; FIFO_DEPTH, default 8, output FIFO entries, power of two, at least RD_LAT+1.
REQ-002 Width W = 4*BATCH*RES_W, with BATCH and RES_W from GLOBAL_PARAM.
REQ-003 Ports are one per line below; the block has one clock, and reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state is captured on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a readout job.
REQ-007 grp_cnt  in  bw(GRP_NUM)+1  number of PE groups to read; sampled when start is accepted.
REQ-008 row_cnt  in  ADDR_W+1  number of addresses per group; sampled when start is accepted.
REQ-009 busy  out  1  high while a job is active.
REQ-010 done  out  1  one-cycle pulse when a job completes.
REQ-011 rd_sel  out  bw(GRP_NUM)  group select toward the PE array.
REQ-012 abuf_rd_addr  out  ADDR_W  read address toward the PE array.
REQ-013 abuf_rd_en  out  1  read strobe toward the PE array.
REQ-014 abuf_rd_data  in  W  read return, 4 PEs x BATCH x RES_W.
REQ-015 out_data  out  W  result word.
REQ-016 out_valid  out  1  output valid.
REQ-017 out_ready  in  1  output ready from the consumer.
REQ-018 out_last  out  1  marks the final word of a job.

Function
REQ-019 Read order: group-major; for g = 0..grp_cnt-1, addr = 0..row_cnt-1; rd_sel=g and abuf_rd_addr=addr are driven in the same cycle as abuf_rd_en.
REQ-020 FSM states: IDLE, READ, DRAIN.
- IDLE->READ on start when both counts are nonzero.
- READ->DRAIN in the cycle the last read is issued.
- DRAIN->IDLE when the last word handshakes on the output.
REQ-021 start when grp_cnt==0 or row_cnt==0: no reads are issued, done pulses the next cycle, busy stays low.
REQ-022 start while busy is ignored; the running job is unaffected.
REQ-023 Return capture: abuf_rd_en delayed RD_LAT cycles through a shift register forms the capture strobe; abuf_rd_data is pushed into the FIFO on that strobe.
REQ-024 Credit rule: a read issues only if (FIFO occupancy + reads in flight) < FIFO_DEPTH; the FIFO never overflows and returned data is never dropped.
REQ-025 Otherwise a read issues every cycle in READ, giving full throughput when out_ready is held high.
REQ-026 Output handshake: a word transfers when out_valid && out_ready.
- out_data, out_valid and out_last hold stable while out_valid is high and out_ready is low.
- out_valid is high whenever the FIFO is non-empty (first-word fall-through or a registered head; either is acceptable if REQ-027 holds).
REQ-027 Latency: the first out_valid rises at most RD_LAT+2 cycles after start is accepted.
REQ-028 out_last is high only on word number grp_cnt*row_cnt of the job.
REQ-029 done pulses in the cycle after the out_last handshake, with busy falling at the same time.
REQ-030 The FIFO may push and pop in the same cycle; occupancy is then unchanged, including when the FIFO is full or empty.
REQ-031 The address counter wraps to 0 and the group counter increments when addr==row_cnt-1.

Reset
REQ-032 Asserting rst (low) asynchronously sets: FSM=IDLE; busy, done, abuf_rd_en, out_valid and out_last to 0; rd_sel and abuf_rd_addr to 0; FIFO empty; in-flight shift register cleared.
REQ-033 Reset in mid-job abandons the job; data returning after reset release is not captured, and no done pulse is produced.
REQ-034 Release of rst is synchronized internally; the first start is accepted no earlier than the second rising edge after release.

Verification
REQ-035 grp_cnt=2, row_cnt=3, out_ready=1, RD_LAT=2 -> reads (g,a) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) on consecutive cycles; 6 words out in order; out_last on word 6; done one cycle later.
REQ-036 grp_cnt=8, row_cnt=256, out_ready held low after start -> exactly FIFO_DEPTH reads issue, then abuf_rd_en stays 0; raising out_ready resumes with no lost or duplicated words (2048 total).
REQ-037 out_ready toggling on a 1-in-3 pattern, grp_cnt=1, row_cnt=16 -> out_data held stable while stalled; 16 words in address order.
REQ-038 start with row_cnt=0 -> zero reads; done pulses at T+1; busy never high.
REQ-039 Second start pulse mid-job -> ignored; the word count equals the first job only.
REQ-040 rst driven low during READ with the FIFO half full -> all outputs 0 within the same cycle; a new job after release returns only its own data.

Source files
------------

// File: rtl/abuf_reader.sv
// abuf_reader: reads the PE accumulation buffers group by group, address by address, and
// streams the returned words through a credit-gated output FIFO with valid/ready/last.
module abuf_reader #(
  parameter int unsigned PE_NUM     = 32,
  parameter int unsigned BUF_DEPTH  = 256,
  parameter int unsigned ADDR_W     = $clog2(BUF_DEPTH),
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BATCH      = 2,
  parameter int unsigned RES_W      = 8,
  localparam int unsigned GRP_NUM   = PE_NUM / 4,
  localparam int unsigned GW        = $clog2(GRP_NUM),
  localparam int unsigned W         = 4 * BATCH * RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GW:0]       grp_cnt,
  input  logic [ADDR_W:0]   row_cnt,
  output logic              busy,
  output logic              done,
  output logic [GW-1:0]     rd_sel,
  output logic [ADDR_W-1:0] abuf_rd_addr,
  output logic              abuf_rd_en,
  input  logic [W-1:0]      abuf_rd_data,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = FAW + 1;

  localparam logic [GW:0]     G_ONE = {{GW{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] R_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e              state_q;
  logic [1:0]          rst_sync_q;
  logic [GW:0]         grp_q, cur_g_q;
  logic [ADDR_W:0]     row_q, cur_a_q;
  logic                rd_last_q;
  logic [RD_LAT-1:0]   en_pipe_q, last_pipe_q;
  logic [CW-1:0]       fifo_cnt_q, inflight_q;
  logic [FAW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [W-1:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last_q;

  logic [CW:0] occ_sum;
  logic        credit_ok, start_ok, cnt_nz, first_last, row_end, grp_end;
  logic        issue, rd_fire, rd_fire_last, push, pop;

  assign out_valid = (fifo_cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & mem_last_q[rd_ptr_q];

  always_comb begin
    occ_sum      = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    credit_ok    = occ_sum < (CW+1)'(FIFO_DEPTH);
    start_ok     = (state_q == StIdle) && start && rst_sync_q[1];
    cnt_nz       = (grp_cnt != '0) && (row_cnt != '0);
    first_last   = (grp_cnt == G_ONE) && (row_cnt == R_ONE);
    row_end      = (cur_a_q == row_q - R_ONE);
    grp_end      = (cur_g_q == grp_q - G_ONE);
    issue        = (state_q == StRead) && credit_ok;
    // The first read goes out with start; IDLE always has an empty FIFO and nothing in flight.
    rd_fire      = (start_ok && cnt_nz) || issue;
    rd_fire_last = start_ok ? first_last : (row_end && grp_end);
    push         = en_pipe_q[RD_LAT-1];
    pop          = out_valid && out_ready;
  end

  // Reset asserts asynchronously but releases through two flops before start is honoured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      busy         <= 1'b0;
      done         <= 1'b0;
      abuf_rd_en   <= 1'b0;
      rd_sel       <= '0;
      abuf_rd_addr <= '0;
      grp_q        <= '0;
      row_q        <= '0;
      cur_g_q      <= '0;
      cur_a_q      <= '0;
      rd_last_q    <= 1'b0;
    end else begin
      done       <= 1'b0;
      abuf_rd_en <= rd_fire;
      rd_last_q  <= rd_fire && rd_fire_last;
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            if (cnt_nz) begin
              grp_q        <= grp_cnt;
              row_q        <= row_cnt;
              rd_sel       <= '0;
              abuf_rd_addr <= '0;
              busy         <= 1'b1;
              if (row_cnt == R_ONE) begin
                cur_g_q <= G_ONE;
                cur_a_q <= '0;
              end else begin
                cur_g_q <= '0;
                cur_a_q <= R_ONE;
              end
              state_q <= first_last ? StDrain : StRead;
            end else begin
              done <= 1'b1;
            end
          end
        end
        StRead: begin
          if (issue) begin
            rd_sel       <= cur_g_q[GW-1:0];
            abuf_rd_addr <= cur_a_q[ADDR_W-1:0];
            if (row_end) begin
              cur_a_q <= '0;
              cur_g_q <= cur_g_q + G_ONE;
            end else begin
              cur_a_q <= cur_a_q + R_ONE;
            end
            if (row_end && grp_end) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && out_last) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // In-flight tracking and FIFO bookkeeping; the last-word tag rides alongside the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_pipe_q   <= '0;
      last_pipe_q <= '0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      en_pipe_q[0]   <= abuf_rd_en;
      last_pipe_q[0] <= rd_last_q;
      for (int i = 1; i < RD_LAT; i++) begin
        en_pipe_q[i]   <= en_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
      case ({rd_fire, push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]      <= abuf_rd_data;
      mem_last_q[wr_ptr_q] <= last_pipe_q[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_abuf_reader.sv
// Directed bench for abuf_reader: a latency-RD_LAT buffer model feeds tagged words, and a
// negedge monitor records reads, output transfers, done pulses and stall behaviour.
module tb_abuf_reader;

  localparam int RD_LAT = 2;

  logic        clk, rst, start, busy, done, abuf_rd_en, out_valid, out_ready, out_last;
  logic [3:0]  grp_cnt;
  logic [8:0]  row_cnt;
  logic [2:0]  rd_sel;
  logic [7:0]  abuf_rd_addr;
  logic [63:0] abuf_rd_data, out_data;

  int n_assert, n_fail, cyc, epoch, start_cyc;
  int rd_g[$], rd_a[$], rd_cyc[$];
  logic [63:0] wd[$];
  logic wl[$];
  int first_valid_cyc, last_cyc, done_cnt, done_cyc, stall_bad;
  bit busy_seen, prev_stall;
  logic [63:0] prev_data;
  logic prev_last;
  logic [63:0] mdl_q [RD_LAT];

  abuf_reader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .grp_cnt      (grp_cnt),
    .row_cnt      (row_cnt),
    .busy         (busy),
    .done         (done),
    .rd_sel       (rd_sel),
    .abuf_rd_addr (abuf_rd_addr),
    .abuf_rd_en   (abuf_rd_en),
    .abuf_rd_data (abuf_rd_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  function automatic logic [63:0] mk(input int ep, input int g, input int a);
    return {ep[15:0], g[15:0], a[15:0], 16'h5A5A};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    mdl_q[0] <= mk(epoch, int'(rd_sel), int'(abuf_rd_addr));
    for (int i = 1; i < RD_LAT; i++) mdl_q[i] <= mdl_q[i-1];
  end
  assign abuf_rd_data = mdl_q[RD_LAT-1];

  always @(negedge clk) begin
    if (abuf_rd_en) begin
      rd_g.push_back(int'(rd_sel));
      rd_a.push_back(int'(abuf_rd_addr));
      rd_cyc.push_back(cyc);
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      wd.push_back(out_data);
      wl.push_back(out_last);
      if (out_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rd_g.delete(); rd_a.delete(); rd_cyc.delete(); wd.delete(); wl.delete();
    first_valid_cyc = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1;
    stall_bad = 0; busy_seen = 1'b0;
  endtask

  task automatic start_job(input int g, input int r);
    grp_cnt = 4'(g); row_cnt = 9'(r); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done_cnt == 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 64'(done_cnt > 0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic check_reads(input int g, input int r);
    chk("n_reads", 64'(rd_g.size()), 64'(g * r));
    for (int i = 0; i < rd_g.size() && i < g * r; i++) begin
      chk("rd_sel", 64'(rd_g[i]), 64'(i / r));
      chk("rd_addr", 64'(rd_a[i]), 64'(i % r));
    end
  endtask

  task automatic check_words(input int g, input int r, input int ep);
    chk("n_words", 64'(wd.size()), 64'(g * r));
    for (int i = 0; i < wd.size() && i < g * r; i++) begin
      chk("word", wd[i], mk(ep, i / r, i % r));
      chk("last_flag", 64'(wl[i]), 64'(i == g * r - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0; epoch = 0; cyc = 0;
    rst = 1'b0; start = 1'b0; grp_cnt = '0; row_cnt = '0; out_ready = 1'b1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    clr();
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rd_en", 64'(abuf_rd_en), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_sel", 64'(rd_sel), 64'(0));
    chk("rst_addr", 64'(abuf_rd_addr), 64'(0));

    // Start held across the first edge after release must be ignored.
    rst = 1'b1; grp_cnt = 4'd1; row_cnt = 9'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("sync_start_busy", 64'(busy), 64'(0));
    chk("sync_start_rd_en", 64'(abuf_rd_en), 64'(0));
    repeat (3) @(posedge clk); #1;
    chk("sync_no_done", 64'(done_cnt), 64'(0));

    // 2 groups x 3 rows, full throughput.
    clr(); start_job(2, 3); wait_done(50);
    check_reads(2, 3);
    if (rd_cyc.size() == 6) chk("rd_back_to_back", 64'(rd_cyc[5] - rd_cyc[0]), 64'(5));
    chk("first_valid_latency",
        64'(first_valid_cyc >= 0 && (first_valid_cyc - start_cyc - 1) <= RD_LAT + 2), 64'(1));
    check_words(2, 3, 0);
    chk("done_after_last", 64'(done_cyc - last_cyc), 64'(1));
    chk("done_once", 64'(done_cnt), 64'(1));
    chk("busy_low_after_done", 64'(busy), 64'(0));

    // Consumer stalled: credits cap reads at the FIFO depth.
    clr(); out_ready = 1'b0; start_job(8, 256);
    repeat (30) @(posedge clk); #1;
    chk("credit_reads", 64'(rd_g.size()), 64'(8));
    chk("credit_rd_en_low", 64'(abuf_rd_en), 64'(0));
    chk("credit_fifo_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1; wait_done(5000);
    check_reads(8, 256);
    check_words(8, 256, 0);
    chk("credit_stall_stable", 64'(stall_bad), 64'(0));

    // Ready high one cycle in three.
    clr(); out_ready = 1'b0; start_job(1, 16);
    for (int k = 0; k < 300 && done_cnt == 0; k++) begin
      out_ready = (k % 3 == 2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; wait_done(20);
    check_words(1, 16, 0);
    chk("toggle_stall_stable", 64'(stall_bad), 64'(0));

    // Empty jobs.
    clr(); start_job(2, 0);
    chk("zero_row_done", 64'(done), 64'(1));
    chk("zero_row_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("zero_row_done_pulse", 64'(done), 64'(0));
    start_job(0, 5);
    chk("zero_grp_done", 64'(done), 64'(1));
    repeat (3) @(posedge clk); #1;
    chk("zero_reads", 64'(rd_g.size()), 64'(0));
    chk("zero_busy_never", 64'(busy_seen), 64'(0));
    chk("zero_done_cnt", 64'(done_cnt), 64'(2));

    // Second start while busy.
    clr(); start_job(1, 4);
    @(posedge clk); #1;
    start_job(2, 5);
    wait_done(50);
    repeat (10) @(posedge clk); #1;
    check_reads(1, 4);
    check_words(1, 4, 0);
    chk("restart_done_cnt", 64'(done_cnt), 64'(1));

    // Reset mid-read with the FIFO half full.
    clr(); out_ready = 1'b0; start_job(2, 16);
    repeat (6) @(posedge clk); #1;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_rd_en", 64'(abuf_rd_en), 64'(0));
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_last", 64'(out_last), 64'(0));
    chk("mid_rst_sel", 64'(rd_sel), 64'(0));
    chk("mid_rst_addr", 64'(abuf_rd_addr), 64'(0));
    chk("mid_rst_data", out_data, 64'(0));
    repeat (2) @(posedge clk); #1;
    rst = 1'b1; epoch = 1; clr(); out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("post_rst_no_words", 64'(wd.size()), 64'(0));
    chk("post_rst_no_done", 64'(done_cnt), 64'(0));
    chk("post_rst_no_reads", 64'(rd_g.size()), 64'(0));
    clr(); start_job(1, 3); wait_done(50);
    check_reads(1, 3);
    check_words(1, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
